// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: one partial product per clock,
// registered 2*WIDTH-bit product and a done flag (fp) held while in DONE.
module shift_add_multiplier #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     x_parallel,
    input  logic [WIDTH-1:0]     y_parallel,
    input  logic                 fx,
    input  logic                 fy,
    output logic [2*WIDTH-1:0]   product,
    output logic                 fp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MULT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 fp_q, fp_d;
    logic                 armed_q, armed_d;

    logic                 both_ready;
    logic                 start;
    logic [WIDTH:0]       addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     shifted;

    assign both_ready = fx & fy;
    assign start      = (state_q == IDLE) & both_ready & armed_q;

    // acc_q[WIDTH] is always zero after the shift, so adding the full accumulator
    // equals adding its low WIDTH bits; the WIDTH+1-bit sum keeps the carry.
    assign addend  = mplr_q[0] ? {1'b0, mcand_q} : '0;
    assign sum     = acc_q + addend;
    assign shifted = {sum, mplr_q} >> 1;

    always_comb begin
        // NOTE: every *_d gets a default before the case so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        armed_d   = armed_q;

        // Arming requires seeing the ready pair low once, so one assertion of
        // fx/fy produces exactly one multiplication.
        if (start)
            armed_d = 1'b0;
        else if (!both_ready)
            armed_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start)
                    state_d = LOAD;
            end
            LOAD: begin
                mcand_d = x_parallel;
                mplr_d  = y_parallel;
                acc_d   = '0;
                count_d = '0;
                state_d = MULT;
            end
            MULT: begin
                acc_d   = shifted[2*WIDTH:WIDTH];
                mplr_d  = shifted[WIDTH-1:0];
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    product_d = shifted[2*WIDTH-1:0];
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (!both_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        fp_d = (state_q == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of ordering.
    // NOTE: there is no memory array here; every register, datapath included,
    // is cleared by reset so no stale product survives an abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
            fp_q      <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
            fp_q      <= fp_d;
            armed_q   <= armed_d;
        end
    end

    assign product = product_q;
    assign fp      = fp_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: stimulus queues expected products
// and fp rise cycles; a monitor compares them whenever fp rises.
module tb_shift_add_multiplier;

    localparam int WIDTH   = 12;
    localparam int LATENCY = WIDTH + 2;

    logic                clk;
    logic                reset;
    logic [WIDTH-1:0]    x_parallel;
    logic [WIDTH-1:0]    y_parallel;
    logic                fx;
    logic                fy;
    logic [2*WIDTH-1:0]  product;
    logic                fp;

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        int                 rise_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    shift_add_multiplier #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .x_parallel (x_parallel),
        .y_parallel (y_parallel),
        .fx         (fx),
        .fy         (fy),
        .product    (product),
        .fp         (fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*WIDTH-1:0] ref_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int unsigned pa = a;
        int unsigned pb = b;
        return (2*WIDTH)'(pa * pb);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Outputs are sampled at the falling edge; inputs change 1 time unit later.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Caller guarantees IDLE with the arm flag set (fx/fy seen low on the last edge).
    task automatic start_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        x_parallel = a;
        y_parallel = b;
        fx = 1'b1;
        fy = 1'b1;
        e.prod     = ref_mult(a, b);
        e.rise_cyc = cyc + 1 + LATENCY;
        exp_q.push_back(e);
    endtask

    task automatic wait_fp();
        int n = 0;
        while (fp !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        if (fp !== 1'b1)
            check("fp_timeout", {31'd0, fp}, 32'd1);
    endtask

    task automatic release_ready();
        fx = 1'b0;
        fy = 1'b0;
        step(2);
    endtask

    // Monitor: every rising fp must match the oldest outstanding request.
    initial begin
        logic fp_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                fp_prev = 1'b0;
            end else begin
                if (fp === 1'b1 && fp_prev === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_fp", {31'd0, fp}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("product", {8'd0, product}, {8'd0, e.prod});
                        check("fp_latency", cyc, e.rise_cyc);
                    end
                end
                fp_prev = fp;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] a, b;
        int fp_cycles;

        reset = 1'b1;
        fx = 1'b0;
        fy = 1'b0;
        x_parallel = '0;
        y_parallel = '0;
        step(2);
        check("reset_product", {8'd0, product}, 32'd0);
        check("reset_fp", {31'd0, fp}, 32'd0);
        reset = 1'b0;
        step(2);
        check("post_reset_fp", {31'd0, fp}, 32'd0);

        // Basic product and latency.
        start_mult(12'h123, 12'h456);
        wait_fp();
        check("t1_product", {8'd0, product}, 32'h0004EDC2);
        release_ready();

        // Largest operands exercise the carry path.
        start_mult(12'hFFF, 12'hFFF);
        wait_fp();
        check("t2_product", {8'd0, product}, 32'h00FFE001);
        release_ready();

        start_mult(12'h000, 12'hABC);
        wait_fp();
        check("t3_zero", {8'd0, product}, 32'h0);
        release_ready();
        start_mult(12'hABC, 12'h001);
        wait_fp();
        check("t3_one", {8'd0, product}, 32'h00000ABC);
        release_ready();

        // Holding fx/fy keeps DONE with a stable product and no restart.
        start_mult(12'h5A5, 12'h3C3);
        wait_fp();
        for (int i = 0; i < 5; i++) begin
            step(10);
            check("t4_hold_fp", {31'd0, fp}, 32'd1);
            check("t4_hold_product", {8'd0, product}, {8'd0, ref_mult(12'h5A5, 12'h3C3)});
        end
        fy = 1'b0;
        step(2);
        check("t4_fp_dropped", {31'd0, fp}, 32'd0);
        check("t4_product_kept", {8'd0, product}, {8'd0, ref_mult(12'h5A5, 12'h3C3)});
        fx = 1'b0;
        step(1);
        start_mult(12'h321, 12'h0F0);
        wait_fp();
        release_ready();

        // Reset mid-computation, then no start until the ready pair is re-armed.
        start_mult(12'h7E1, 12'h19B);
        step(8);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("t5_reset_product", {8'd0, product}, 32'd0);
        check("t5_reset_fp", {31'd0, fp}, 32'd0);
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(10);
            check("t5_no_restart", {31'd0, fp}, 32'd0);
        end
        check("t5_product_zero", {8'd0, product}, 32'd0);
        release_ready();
        start_mult(12'h0AB, 12'hCD0);
        wait_fp();
        release_ready();

        // Operand changes after LOAD are ignored.
        start_mult(12'h9C4, 12'h2E7);
        step(4);
        x_parallel = 12'h111;
        y_parallel = 12'hEEE;
        wait_fp();
        check("t6_captured", {8'd0, product}, {8'd0, ref_mult(12'h9C4, 12'h2E7)});
        release_ready();

        // Ready dropped mid-computation: fp pulses exactly one cycle.
        start_mult(12'h432, 12'h876);
        step(5);
        fx = 1'b0;
        fy = 1'b0;
        fp_cycles = 0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            if (fp === 1'b1) fp_cycles++;
        end
        check("t7_fp_one_cycle", fp_cycles, 32'd1);
        check("t7_product", {8'd0, product}, {8'd0, ref_mult(12'h432, 12'h876)});

        // Randomised operands with optional mid-computation operand disturbance.
        for (int i = 0; i < 20; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            if (i % 7 == 3) a = '1;
            if (i % 5 == 4) b = '0;
            start_mult(a, b);
            if ($urandom_range(0, 1) == 1) begin
                step($urandom_range(2, 12));
                x_parallel = WIDTH'($urandom);
                y_parallel = WIDTH'($urandom);
            end
            wait_fp();
            step($urandom_range(0, 5));
            check("rand_hold_fp", {31'd0, fp}, 32'd1);
            release_ready();
        end

        step(2);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
